// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// instruction field positions, the default reset PC and an alignment helper.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    // Instruction memory is word addressed, so the two low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection for the fetch unit. Picks the redirect target by fixed
// priority and reports whether that target was misaligned.
module pc_next
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] target;

    // Register jumps win over absolute jumps, which win over branches;
    // the jump region comes from the delay-slot PC's upper nibble.
    always_comb begin
        target = pc_plus4;
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            target = branch_target;
        end
        next_pc    = word_align(target);
        misaligned = |target[1:0];
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads to instruction memory, holds
// the returned word for decode, and applies redirects and flushes.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        misalign_err
);

    fetch_state_t state;
    logic [31:0]  flush_pc_q;
    logic [31:0]  flush_aligned;
    logic [31:0]  sel_pc;
    logic         sel_misaligned;

    assign flush_aligned = word_align(flush_pc);
    assign opcode        = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct         = instr[FUNCT_MSB:FUNCT_LSB];

    pc_next u_pc_next (
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .next_pc       (sel_pc),
        .misaligned    (sel_misaligned)
    );

    // Fetch FSM; every launch into REQ loads pc, pc_plus4 and imem_addr together
    // so the request address stays constant until memory acknowledges it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            pc_plus4     <= RESET_PC + 32'd4;
            instr        <= '0;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            misalign_err <= 1'b0;
            flush_pc_q   <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                    if (flush) begin
                        pc        <= flush_aligned;
                        pc_plus4  <= flush_aligned + 32'd4;
                        imem_addr <= flush_aligned;
                    end
                end
                REQ: begin
                    if (flush && imem_ack) begin
                        pc        <= flush_aligned;
                        pc_plus4  <= flush_aligned + 32'd4;
                        imem_addr <= flush_aligned;
                    end else if (flush) begin
                        state      <= DRAIN;
                        imem_req   <= 1'b0;
                        flush_pc_q <= flush_aligned;
                    end else if (imem_ack) begin
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        state       <= REQ;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        pc          <= flush_aligned;
                        pc_plus4    <= flush_aligned + 32'd4;
                        imem_addr   <= flush_aligned;
                    end else if (instr_ready) begin
                        state       <= REQ;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        pc          <= sel_pc;
                        pc_plus4    <= sel_pc + 32'd4;
                        imem_addr   <= sel_pc;
                        if (sel_misaligned) begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        if (flush) begin
                            pc        <= flush_aligned;
                            pc_plus4  <= flush_aligned + 32'd4;
                            imem_addr <= flush_aligned;
                        end else begin
                            pc        <= flush_pc_q;
                            pc_plus4  <= flush_pc_q + 32'd4;
                            imem_addr <= flush_pc_q;
                        end
                    end else if (flush) begin
                        flush_pc_q <= flush_aligned;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a transaction-level
// reference model compared against the DUT on every falling edge.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .opcode        (opcode),
        .funct         (funct),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clearRedirects();
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        jr            = 1'b0;
        flush         = 1'b0;
        imem_ack      = 1'b0;
    endtask

    // Reference model: tracks, per transaction, whether a read is outstanding,
    // a word is waiting for decode, or a stale read is being drained.
    logic        m_live = 1'b0;
    logic        m_idle, m_req, m_valid, m_drain, m_mis;
    logic [31:0] m_fetch, m_pc, m_instr, m_restart;
    logic [31:0] m_tgt;

    always @(posedge clk) begin
        if (rst) begin
            m_live  = 1'b1;
            m_idle  = 1'b1;
            m_req   = 1'b0;
            m_valid = 1'b0;
            m_drain = 1'b0;
            m_mis   = 1'b0;
            m_fetch = 32'h0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
        end else if (m_live) begin
            if (m_idle) begin
                m_idle = 1'b0;
                m_req  = 1'b1;
                if (flush) m_fetch = flush_pc - (flush_pc % 4);
            end else if (m_drain) begin
                if (flush) m_restart = flush_pc - (flush_pc % 4);
                if (imem_ack) begin
                    m_drain = 1'b0;
                    m_req   = 1'b1;
                    m_fetch = m_restart;
                end
            end else if (m_req) begin
                if (flush && imem_ack) begin
                    m_fetch = flush_pc - (flush_pc % 4);
                end else if (flush) begin
                    m_req     = 1'b0;
                    m_drain   = 1'b1;
                    m_restart = flush_pc - (flush_pc % 4);
                end else if (imem_ack) begin
                    m_req   = 1'b0;
                    m_valid = 1'b1;
                    m_instr = imem_rdata;
                    m_pc    = m_fetch;
                end
            end else if (m_valid) begin
                if (flush) begin
                    m_valid = 1'b0;
                    m_req   = 1'b1;
                    m_fetch = flush_pc - (flush_pc % 4);
                end else if (instr_ready) begin
                    if (jr) m_tgt = jr_target;
                    else if (jump) m_tgt = ((m_pc + 32'd4) & 32'hF000_0000) | {4'b0, jump_index, 2'b00};
                    else if (branch_taken) m_tgt = branch_target;
                    else m_tgt = m_pc + 32'd4;
                    if (m_tgt % 4 != 0) m_mis = 1'b1;
                    m_valid = 1'b0;
                    m_req   = 1'b1;
                    m_fetch = m_tgt - (m_tgt % 4);
                end
            end
        end
    end

    // Compare the DUT against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("imem_req", {31'b0, imem_req}, {31'b0, m_req});
            checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
            checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
            if (m_req) checkOutput("imem_addr", imem_addr, m_fetch);
            if (m_valid) begin
                checkOutput("instr", instr, m_instr);
                checkOutput("pc", pc, m_pc);
                checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
                checkOutput("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
                checkOutput("funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
            end
        end
    end

    // Directed sequence with literal expectations that pin the model.
    initial begin
        rst           = 1'b1;
        imem_rdata    = 32'h0;
        branch_target = 32'h0;
        jump_index    = 26'h0;
        jr_target     = 32'h0;
        flush_pc      = 32'h0;
        clearRedirects();
        imem_ack      = 1'b1;
        applyStimulus(2);
        checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_pc4", pc_plus4, 32'h4);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);

        // Ack in the IDLE cycle after release must be ignored.
        rst = 1'b0;
        applyStimulus(1);
        imem_ack = 1'b0;
        checkOutput("post_rst_req", {31'b0, imem_req}, 32'd1);
        checkOutput("post_rst_valid", {31'b0, instr_valid}, 32'd0);

        // First fetch, acked after one cycle.
        applyStimulus(1);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        applyStimulus(1);
        imem_ack = 1'b0;
        checkOutput("first_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("first_opcode", {26'b0, opcode}, 32'h08);
        checkOutput("first_pc", pc, 32'h0);
        checkOutput("first_pc4", pc_plus4, 32'h4);

        // Redirects while decode is stalled are ignored.
        jr = 1'b1; jr_target = 32'h300;
        applyStimulus(2);
        checkOutput("stall_pc", pc, 32'h0);
        jr = 1'b0; instr_ready = 1'b1;
        applyStimulus(1);
        instr_ready = 1'b0;
        checkOutput("seq_addr", imem_addr, 32'h4);

        // Ack delayed by three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("wait_addr", imem_addr, 32'h4);
            checkOutput("wait_req", {31'b0, imem_req}, 32'd1);
        end
        imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
        applyStimulus(1);
        imem_ack = 1'b0;
        checkOutput("second_pc", pc, 32'h4);

        // All three redirects at once: register jump wins.
        jr = 1'b1; jr_target = 32'h40; jump = 1'b1; jump_index = 26'h123;
        branch_taken = 1'b1; branch_target = 32'h200; instr_ready = 1'b1;
        applyStimulus(1);
        clearRedirects();
        checkOutput("prio_addr", imem_addr, 32'h40);

        // Move into the 0x1000_0000 region, then take an absolute jump there.
        imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
        applyStimulus(1);
        imem_ack = 1'b0; jr = 1'b1; jr_target = 32'h1000_0000; instr_ready = 1'b1;
        applyStimulus(1);
        clearRedirects();
        imem_ack = 1'b1; imem_rdata = 32'h0C00_0000;
        applyStimulus(1);
        imem_ack = 1'b0;
        checkOutput("region_pc", pc, 32'h1000_0000);
        jump = 1'b1; jump_index = 26'h10; instr_ready = 1'b1;
        applyStimulus(1);
        clearRedirects();
        checkOutput("jump_addr", imem_addr, 32'h1000_0040);

        // Flush before ack: drain the stale ack, restart at 0x80.
        flush = 1'b1; flush_pc = 32'h80;
        applyStimulus(1);
        flush = 1'b0;
        checkOutput("drain_req", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        applyStimulus(1);
        imem_ack = 1'b0;
        checkOutput("restart_addr", imem_addr, 32'h80);
        checkOutput("stale_valid", {31'b0, instr_valid}, 32'd0);

        // Flush together with ack restarts directly.
        flush = 1'b1; flush_pc = 32'h90; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
        applyStimulus(1);
        clearRedirects();
        checkOutput("flush_ack_addr", imem_addr, 32'h90);

        // Second flush during drain overrides the restart address.
        flush = 1'b1; flush_pc = 32'hB0;
        applyStimulus(1);
        flush_pc = 32'hA0;
        applyStimulus(1);
        flush = 1'b0; imem_ack = 1'b1;
        applyStimulus(1);
        imem_ack = 1'b0;
        checkOutput("reflush_addr", imem_addr, 32'hA0);

        // Misaligned branch target: sticky error, aligned fetch.
        imem_ack = 1'b1; imem_rdata = 32'h1000_0001;
        applyStimulus(1);
        imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h102; instr_ready = 1'b1;
        applyStimulus(1);
        clearRedirects();
        checkOutput("mis_addr", imem_addr, 32'h100);
        checkOutput("mis_flag", {31'b0, misalign_err}, 32'd1);
        imem_ack = 1'b1;
        applyStimulus(1);
        imem_ack = 1'b0; instr_ready = 1'b1;
        applyStimulus(1);
        instr_ready = 1'b0;
        checkOutput("mis_sticky", {31'b0, misalign_err}, 32'd1);
        checkOutput("after_mis_addr", imem_addr, 32'h104);

        // Flush in HOLD beats an accepting redirect.
        imem_ack = 1'b1;
        applyStimulus(1);
        imem_ack = 1'b0; flush = 1'b1; flush_pc = 32'h200; jr = 1'b1; jr_target = 32'h300; instr_ready = 1'b1;
        applyStimulus(1);
        clearRedirects();
        checkOutput("hold_flush_addr", imem_addr, 32'h200);

        // pc_plus4 wraps at the top of the address space.
        imem_ack = 1'b1;
        applyStimulus(1);
        imem_ack = 1'b0; jr = 1'b1; jr_target = 32'hFFFF_FFFC; instr_ready = 1'b1;
        applyStimulus(1);
        clearRedirects();
        imem_ack = 1'b1;
        applyStimulus(1);
        imem_ack = 1'b0;
        checkOutput("wrap_pc4", pc_plus4, 32'h0);
        instr_ready = 1'b1;
        applyStimulus(1);
        instr_ready = 1'b0;
        checkOutput("wrap_addr", imem_addr, 32'h0);

        // Reset in the middle of an outstanding request.
        rst = 1'b1; imem_ack = 1'b1;
        applyStimulus(1);
        checkOutput("mid_rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("mid_rst_mis", {31'b0, misalign_err}, 32'd0);
        rst = 1'b0;
        applyStimulus(1);
        imem_ack = 1'b0;
        checkOutput("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        applyStimulus(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
